// File: rtl/path_sequencer.sv
// Path sequencer: buffers a CPU-written node path, then steps through it,
// issuing (curr,next) turn requests and latching the returned turn codes.
// Ports: clk_3125KHz/rst_n (sync, active-low); path_wr_en/path_node/
//   path_last/path_ready load the buffer; start launches traversal;
//   node_flag marks node arrival; req_* handshake with the turn datapath;
//   turn_valid/turn_in return the turn; turn_flag/turn_strobe,
//   realtime_pos, path_done, busy, err_overflow report status.
// Option: define RETURN_PATH_EN to run a reverse leg back to buf[0].
module path_sequencer #(
    parameter int NODE_W  = 5,
    parameter int MAX_LEN = 16
) (
    input  logic              clk_3125KHz,
    input  logic              rst_n,
    input  logic              path_wr_en,
    input  logic [NODE_W-1:0] path_node,
    input  logic              path_last,
    output logic              path_ready,
    input  logic              start,
    input  logic              node_flag,
    output logic              req_valid,
    output logic [NODE_W-1:0] req_curr,
    output logic [NODE_W-1:0] req_next,
    input  logic              req_ready,
    input  logic              turn_valid,
    input  logic [1:0]        turn_in,
    output logic [1:0]        turn_flag,
    output logic              turn_strobe,
    output logic [NODE_W-1:0] realtime_pos,
    output logic              path_done,
    output logic              busy,
    output logic              err_overflow
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] FULL = IW'(MAX_LEN);
    localparam logic [IW-1:0] TWO  = IW'(2);

    localparam logic [2:0] S_LOAD      = 3'd0;
    localparam logic [2:0] S_ARMED     = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_TURN = 3'd3;
    localparam logic [2:0] S_WAIT_NODE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [NODE_W-1:0] path_mem_q [MAX_LEN];

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     len_q, len_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NODE_W-1:0] pos_q, pos_d;
    logic [1:0]        turn_q, turn_d;
    logic              strobe_q, strobe_d;
    logic              err_q, err_d;
    logic              nf_prev_q;

    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [IW-1:0]     step_idx;
    logic              node_rise;
    logic              launch;

`ifdef RETURN_PATH_EN
    logic dir_q, dir_d;
    // Reverse leg walks the buffer downwards.
    assign step_idx = dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
`else
    assign step_idx = idx_q + 1'b1;
`endif

    assign node_rise = node_flag & ~nf_prev_q;
    // A write in DONE takes priority over a simultaneous start.
    assign launch = start & ((state_q == S_ARMED) |
                    ((state_q == S_DONE) & ~path_wr_en));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        pos_d    = pos_q;
        turn_d   = turn_q;
        strobe_d = 1'b0;
        err_d    = err_q;
        mem_we   = 1'b0;
        mem_addr = len_q[AW-1:0];
`ifdef RETURN_PATH_EN
        dir_d    = dir_q;
`endif
        if (path_wr_en && !path_ready) err_d = 1'b1;
        unique case (state_q)
            S_LOAD: begin
                if (path_wr_en) begin
                    if (len_q == FULL) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        len_d  = len_q + 1'b1;
                    end
                    // The end marker still closes a full buffer.
                    if (path_last) state_d = S_ARMED;
                end
            end
            S_ARMED: ;
            S_ISSUE: begin
                if (req_ready) state_d = S_WAIT_TURN;
            end
            S_WAIT_TURN: begin
                if (turn_valid) begin
                    turn_d   = turn_in;
                    strobe_d = 1'b1;
                    state_d  = S_WAIT_NODE;
                end
            end
            S_WAIT_NODE: begin
                if (node_rise) begin
                    idx_d   = step_idx;
                    pos_d   = path_mem_q[step_idx[AW-1:0]];
                    state_d = S_ISSUE;
`ifdef RETURN_PATH_EN
                    if (dir_q) begin
                        if (step_idx == '0) state_d = S_DONE;
                    end else if (step_idx == len_q - 1'b1) begin
                        dir_d = 1'b1;
                    end
`else
                    if (step_idx == len_q - 1'b1) state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                if (path_wr_en) begin
                    mem_we   = 1'b1;
                    mem_addr = '0;
                    len_d    = IW'(1);
                    state_d  = path_last ? S_ARMED : S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        if (launch) begin
            if (len_q >= TWO) begin
                idx_d   = '0;
                pos_d   = path_mem_q[0];
                state_d = S_ISSUE;
`ifdef RETURN_PATH_EN
                dir_d   = 1'b0;
`endif
            end else begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            len_q     <= '0;
            idx_q     <= '0;
            pos_q     <= '0;
            turn_q    <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            nf_prev_q <= 1'b0;
`ifdef RETURN_PATH_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            turn_q    <= turn_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
            nf_prev_q <= node_flag;
`ifdef RETURN_PATH_EN
            dir_q     <= dir_d;
`endif
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (mem_we) path_mem_q[mem_addr] <= path_node;
    end

    assign path_ready   = (state_q == S_LOAD) | (state_q == S_DONE);
    assign req_valid    = (state_q == S_ISSUE);
    // Node outputs read as zero outside ISSUE so reset leaves them clean.
    assign req_curr     = req_valid ? path_mem_q[idx_q[AW-1:0]] : '0;
    assign req_next     = req_valid ? path_mem_q[step_idx[AW-1:0]] : '0;
    assign turn_flag    = turn_q;
    assign turn_strobe  = strobe_q;
    assign realtime_pos = pos_q;
    assign path_done    = (state_q == S_DONE);
    assign busy         = (state_q != S_LOAD);
    assign err_overflow = err_q;

endmodule

// File: tb/tb_path_sequencer.sv
// Directed bench for path_sequencer: table-driven traversal steps plus
// hand-written sequences for stalls, reset, overflow and one-node paths.
module tb_path_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       path_wr_en;
    logic [4:0] path_node;
    logic       path_last;
    logic       path_ready;
    logic       start;
    logic       node_flag;
    logic       req_valid;
    logic [4:0] req_curr;
    logic [4:0] req_next;
    logic       req_ready;
    logic       turn_valid;
    logic [1:0] turn_in;
    logic [1:0] turn_flag;
    logic       turn_strobe;
    logic [4:0] realtime_pos;
    logic       path_done;
    logic       busy;
    logic       err_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] cur;
        logic [4:0] nxt;
        logic [1:0] turn;
    } step_t;

    step_t steps[$];

    path_sequencer #(.NODE_W(5), .MAX_LEN(16)) dut (
        .clk_3125KHz (clk),
        .rst_n       (rst_n),
        .path_wr_en  (path_wr_en),
        .path_node   (path_node),
        .path_last   (path_last),
        .path_ready  (path_ready),
        .start       (start),
        .node_flag   (node_flag),
        .req_valid   (req_valid),
        .req_curr    (req_curr),
        .req_next    (req_next),
        .req_ready   (req_ready),
        .turn_valid  (turn_valid),
        .turn_in     (turn_in),
        .turn_flag   (turn_flag),
        .turn_strobe (turn_strobe),
        .realtime_pos(realtime_pos),
        .path_done   (path_done),
        .busy        (busy),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] n, input logic last);
        path_wr_en = 1'b1;
        path_node  = n;
        path_last  = last;
        tick();
        path_wr_en = 1'b0;
        path_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (req_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("req_wait", 32'(req_valid), 32'd1);
    endtask

    task automatic do_step(input step_t s, input bit stall,
                           input bit long_node);
        wait_req();
        chk("req_curr", 32'(req_curr), 32'(s.cur));
        chk("req_next", 32'(req_next), 32'(s.nxt));
        chk("done_mid", 32'(path_done), 32'd0);
        if (stall) begin
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("stall_valid", 32'(req_valid), 32'd1);
                chk("stall_curr", 32'(req_curr), 32'(s.cur));
                chk("stall_next", 32'(req_next), 32'(s.nxt));
                chk("stall_strobe", 32'(turn_strobe), 32'd0);
            end
            // Early turn_valid alongside the accept must be ignored.
            turn_valid = 1'b1;
            turn_in    = ~s.turn;
        end
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        turn_valid = 1'b0;
        chk("req_drop", 32'(req_valid), 32'd0);
        chk("no_early_strobe", 32'(turn_strobe), 32'd0);
        tick();
        tick();
        turn_valid = 1'b1;
        turn_in    = s.turn;
        tick();
        turn_valid = 1'b0;
        chk("strobe_hi", 32'(turn_strobe), 32'd1);
        chk("turn_flag", 32'(turn_flag), 32'(s.turn));
        tick();
        chk("strobe_lo", 32'(turn_strobe), 32'd0);
        node_flag = 1'b1;
        tick();
        chk("pos", 32'(realtime_pos), 32'(s.nxt));
        if (long_node) begin
            repeat (49) tick();
            chk("long_pos", 32'(realtime_pos), 32'(s.nxt));
            chk("long_curr", 32'(req_curr), 32'(s.nxt));
        end
        node_flag = 1'b0;
        tick();
    endtask

    task automatic run_steps(input bit stall_first, input int long_k);
        for (int k = 0; k < steps.size(); k++)
            do_step(steps[k], stall_first && k == 0, k == long_k);
        tick();
        chk("done_end", 32'(path_done), 32'd1);
        chk("pos_end", 32'(realtime_pos), 32'(steps[steps.size()-1].nxt));
    endtask

    // Forward pairs of a node list, plus the return leg when enabled.
    task automatic build_steps(input logic [4:0] nodes[$]);
        int n = nodes.size();
        steps.delete();
        for (int i = 0; i < n - 1; i++)
            steps.push_back('{nodes[i], nodes[i+1], 2'(i % 4)});
`ifdef RETURN_PATH_EN
        for (int i = n - 1; i > 0; i--)
            steps.push_back('{nodes[i], nodes[i-1], 2'((i + 1) % 4)});
`endif
    endtask

    initial begin
        step_t      main_tab[5];
        logic [4:0] nl[$];

        main_tab[0] = '{5'd0, 5'd1, 2'd0};
        main_tab[1] = '{5'd1, 5'd2, 2'd3};
        main_tab[2] = '{5'd2, 5'd8, 2'd1};
        main_tab[3] = '{5'd8, 5'd7, 2'd2};
        main_tab[4] = '{5'd7, 5'd6, 2'd0};

        rst_n = 1'b0;
        path_wr_en = 1'b0;
        path_node  = '0;
        path_last  = 1'b0;
        start      = 1'b0;
        node_flag  = 1'b0;
        req_ready  = 1'b0;
        turn_valid = 1'b0;
        turn_in    = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        chk("rst_ready", 32'(path_ready), 32'd1);
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_curr", 32'(req_curr), 32'd0);
        chk("rst_next", 32'(req_next), 32'd0);
        chk("rst_turn", 32'(turn_flag), 32'd0);
        chk("rst_strobe", 32'(turn_strobe), 32'd0);
        chk("rst_pos", 32'(realtime_pos), 32'd0);
        chk("rst_done", 32'(path_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);

        pulse_start();
        chk("load_start_busy", 32'(busy), 32'd0);
        chk("load_start_ready", 32'(path_ready), 32'd1);

        wr(5'd0, 1'b0);
        wr(5'd1, 1'b0);
        wr(5'd2, 1'b0);
        wr(5'd8, 1'b0);
        wr(5'd7, 1'b0);
        wr(5'd6, 1'b1);
        chk("armed_ready", 32'(path_ready), 32'd0);
        chk("armed_valid", 32'(req_valid), 32'd0);
        pulse_start();
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_pos", 32'(realtime_pos), 32'd0);

        steps.delete();
        for (int i = 0; i < 5; i++) steps.push_back(main_tab[i]);
`ifdef RETURN_PATH_EN
        steps.push_back('{5'd6, 5'd7, 2'd1});
        steps.push_back('{5'd7, 5'd8, 2'd2});
        steps.push_back('{5'd8, 5'd2, 2'd3});
        steps.push_back('{5'd2, 5'd1, 2'd0});
        steps.push_back('{5'd1, 5'd0, 2'd1});
`endif
        run_steps(1'b1, 2);
        chk("main_err", 32'(err_overflow), 32'd0);

        // Write beats start in DONE.
        start      = 1'b1;
        path_wr_en = 1'b1;
        path_node  = 5'd0;
        path_last  = 1'b0;
        tick();
        start      = 1'b0;
        path_wr_en = 1'b0;
        chk("wr_win_done", 32'(path_done), 32'd0);
        chk("wr_win_valid", 32'(req_valid), 32'd0);
        chk("wr_win_ready", 32'(path_ready), 32'd1);
        wr(5'd1, 1'b0);
        wr(5'd2, 1'b1);
        pulse_start();
        nl = '{5'd0, 5'd1, 5'd2};
        build_steps(nl);
        run_steps(1'b0, -1);

        // Re-run from DONE, then reset while waiting for the turn.
        pulse_start();
        wait_req();
        chk("rerun_curr", 32'(req_curr), 32'd0);
        chk("rerun_next", 32'(req_next), 32'd1);
        chk("rerun_pos", 32'(realtime_pos), 32'd0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(path_ready), 32'd1);
        chk("mid_rst_valid", 32'(req_valid), 32'd0);
        chk("mid_rst_pos", 32'(realtime_pos), 32'd0);
        chk("mid_rst_turn", 32'(turn_flag), 32'd0);
        chk("mid_rst_done", 32'(path_done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        turn_valid = 1'b1;
        turn_in    = 2'd3;
        tick();
        turn_valid = 1'b0;
        chk("late_turn_strobe", 32'(turn_strobe), 32'd0);
        chk("late_turn_flag", 32'(turn_flag), 32'd0);

        // One-node path goes straight to DONE.
        wr(5'd9, 1'b1);
        chk("one_ready", 32'(path_ready), 32'd0);
        pulse_start();
        chk("one_done", 32'(path_done), 32'd1);
        chk("one_valid", 32'(req_valid), 32'd0);

        // Overflow: 16 fit, the 17th (last) is dropped.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) wr(5'(i), 1'b0);
        chk("full_err", 32'(err_overflow), 32'd0);
        wr(5'd20, 1'b1);
        chk("ovf_err", 32'(err_overflow), 32'd1);
        chk("ovf_ready", 32'(path_ready), 32'd0);
        wr(5'd5, 1'b1);
        chk("armed_wr_err", 32'(err_overflow), 32'd1);
        chk("armed_wr_ready", 32'(path_ready), 32'd0);
        pulse_start();
        nl.delete();
        for (int i = 0; i < 16; i++) nl.push_back(5'(i));
        build_steps(nl);
        run_steps(1'b0, -1);
        chk("ovf_err_end", 32'(err_overflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
Controller that sequences the path-mapping/turn datapath for the bot. It buffers a planned node path written by the CPU, then steps through it one node-arrival at a time. At each step it issues a (current node, next node) request to the turn-computation datapath and latches the returned turn for the motion controller. It also tracks the bot's real-time position and signals path completion.

Parameters:
NODE_W, 5, width of a node ID (nodes 0..29)
MAX_LEN, 16, depth of the path buffer in nodes (power of two, at least 2)

Ports:
clk_3125KHz  in  1  system clock
rst_n  in  1  synchronous active-low reset
path_wr_en  in  1  write path_node into the buffer (accepted only when path_ready=1)
path_node  in  NODE_W  node ID to append
path_last  in  1  qualifies path_wr_en; marks the final node of the path
path_ready  out  1  buffer accepting writes
start  in  1  one-cycle pulse to begin traversal
node_flag  in  1  bot is on a node (level, may last many cycles)
req_valid  out  1  request to turn datapath
req_curr  out  NODE_W  current node of request
req_next  out  NODE_W  next node of request
req_ready  in  1  datapath accepts request
turn_valid  in  1  datapath result valid (one cycle)
turn_in  in  2  turn code from datapath (0 straight, 1 right, 2 U-turn, 3 left)
turn_flag  out  2  latched turn for motion control
turn_strobe  out  1  one-cycle pulse when turn_flag updates
realtime_pos  out  NODE_W  last node reached
path_done  out  1  high in DONE state
busy  out  1  high in any state other than IDLE/LOAD
err_overflow  out  1  sticky: write attempted with buffer full or path_ready=0

Behaviour:
- Reset (rst_n=0 at a clock edge): state=LOAD, len=0, idx=0, path_ready=1. All other outputs are 0. Reset mid-operation abandons the path; no request or strobe is emitted in the following cycle.
- Clock and reset: single clock; reset is synchronous, active-low.
- LOAD state:
  - Each accepted write stores the node at buf[len] and increments len.
  - A write with path_last=1 moves to ARMED and drops path_ready next cycle.
  - A write when len==MAX_LEN or path_ready=0 is dropped and sets err_overflow.
- ARMED state:
  - start=1 with len>=2: idx=0, realtime_pos=buf[0], go to ISSUE.
  - start=1 with len<2: go directly to DONE.
  - start while in LOAD is ignored.
- ISSUE state:
  - Assert req_valid with req_curr=buf[idx] and req_next=buf[idx+1].
  - Hold req_valid and both node outputs stable until req_ready=1. The handshake completes in that cycle.
  - Then go to WAIT_TURN.
- WAIT_TURN state:
  - On turn_valid, latch turn_flag<=turn_in and pulse turn_strobe for 1 cycle. Go to WAIT_NODE.
  - Latency from turn_valid to turn_strobe is 1 cycle.
  - turn_valid arriving in any other state is ignored.
- WAIT_NODE state:
  - node_flag is rising-edge detected with a 1-flop history register.
  - On a rising edge: idx<=idx+1 and realtime_pos<=buf[idx+1].
  - If idx+1==len-1, go to DONE; otherwise go to ISSUE.
  - A node_flag held high does not advance more than once.
  - A rising edge in any other state is ignored.
- DONE state:
  - path_done=1.
  - A start pulse re-runs the same buffered path from ARMED semantics.
  - path_wr_en with path_last=0 while in DONE clears len to 0, returns to LOAD and stores the node as buf[0]. path_done drops.
  - A single-node path (path_last=1 on this write) goes to ARMED.
- Simultaneous events:
  - req_ready and turn_valid in the same cycle as ISSUE: turn_valid is ignored; the datapath must not respond before the request is accepted.
  - start and path_wr_en in the same cycle in DONE: the write wins.
- Widths: idx and len are log2(MAX_LEN)+1 bits. There is no wrap-around; len saturates at MAX_LEN.

Optional Feature:
RETURN_PATH_EN.
- Defined: on reaching DONE for the forward path, the block first runs the reverse traversal, buf[len-1] down to buf[0], through ISSUE/WAIT_TURN/WAIT_NODE. It uses a direction flag and a decrementing idx. path_done asserts only after the return leg reaches buf[0]. busy stays high across both legs.
- Undefined: single forward traversal as described above; the direction flag logic is absent.

Test Plan:
- Load 0,1,2,8,7,6 (last on 6), start. Respond with turn_in 0,3,1,2,0, each given 2 cycles after req_ready=1. Pulse node_flag after each strobe. Required: requests (0,1),(1,2),(2,8),(8,7),(7,6); turn_flag follows the sequence; realtime_pos ends at 6; path_done=1.
- Hold req_ready=0 for 10 cycles in ISSUE → req_valid stays 1 and req_curr/req_next stay stable (0,1); no turn_strobe.
- Hold node_flag high for 50 cycles in WAIT_NODE → idx advances exactly once and realtime_pos changes once.
- Write 17 nodes with MAX_LEN=16 → err_overflow=1, len=16, 17th node dropped. Write path_node=5 with path_last=1 after ARMED → dropped and err_overflow stays 1.
- Assert rst_n=0 for 1 cycle during WAIT_TURN (path 0,1,2) → next cycle state=LOAD, path_ready=1, all outputs 0; a late turn_valid causes no strobe.
- With RETURN_PATH_EN, load 0,1,2,8 → requests (0,1),(1,2),(2,8),(8,2),(2,1),(1,0); path_done only after realtime_pos=0.
